// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart peripheral register map and
// for blocks that master its register interface.
//   - register addresses (UART_CR, UART_TX_RX, UART_DFR, UART_IRQ_M, UART_IRQ_V)
//   - uart_cr_v: field layout of the UART_CR read word
//   - UART_CR_TX_FULL_BIT: bit index of tx_full inside UART_CR
//   - uart_tx_feeder_st_e: state encoding of uart_tx_feeder
package uart_pkg;

    localparam logic [4:0] UART_CR    = 5'h00;
    localparam logic [4:0] UART_TX_RX = 5'h04;
    localparam logic [4:0] UART_DFR   = 5'h08;
    localparam logic [4:0] UART_IRQ_M = 5'h0C;
    localparam logic [4:0] UART_IRQ_V = 5'h10;

    // UART_CR read word. Writes only use the low byte (enables and FIFO levels);
    // the status flags are read-only.
    typedef struct packed {
        logic [23:0] rsvd;
        logic        rx_full;
        logic        tx_full;
        logic        rx_empty;
        logic        tx_empty;
        logic [1:0]  fifo_lvl;
        logic        rx_en;
        logic        tr_en;
    } uart_cr_v;

    localparam int UART_CR_TX_FULL_BIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG_DFR = 3'd1,
        ST_CFG_CR  = 3'd2,
        ST_POLL    = 3'd3,
        ST_SEND    = 3'd4
    } uart_tx_feeder_st_e;

endpackage

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: hardware master for the uart register interface.
// On cfg_start it writes the divider (UART_DFR) and control (UART_CR)
// registers, then repeatedly polls UART_CR.tx_full and, when there is room,
// moves one byte from the valid/ready stream into UART_TX_RX.
//
// Ports:
//   clk, rstn          clock; synchronous active-high reset (rstn=1 resets)
//   cfg_start/cfg_stop one-cycle command pulses
//   cfg_dfr[15:0]      divider value, captured when cfg_start is accepted
//   busy               high whenever the FSM is not idle
//   s_valid/s_data/s_ready  byte stream; a byte transfers when s_valid && s_ready
//   addr/re/we/wd/rd   uart register bus; rd is combinational for the current addr
//   tx_cnt[CNT_W-1:0]  bytes written to UART_TX_RX since the last start (wraps)
//
// Stream handshake: s_ready is high in every SEND cycle regardless of s_valid;
// a byte is consumed exactly in a cycle where both are high, and in that same
// cycle it is written to UART_TX_RX.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter logic [7:0] CR_INIT     = 8'h01,
    parameter int         TX_FULL_BIT = UART_CR_TX_FULL_BIT,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [15:0]      cfg_dfr,
    output logic             busy,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic [4:0]       addr,
    output logic             re,
    output logic             we,
    output logic [31:0]      wd,
    input  logic [31:0]      rd,
    output logic [CNT_W-1:0] tx_cnt
);

    uart_tx_feeder_st_e state_q, state_d;
    logic [15:0]        dfr_q, dfr_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;

    // Only tx_full is consumed from the status word.
    logic unused_rd;
    assign unused_rd = ^rd;

    // Next-state and register updates.
    always_comb begin
        state_d  = state_q;
        dfr_d    = dfr_q;
        tx_cnt_d = tx_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous stop
                if (cfg_start) begin
                    dfr_d    = cfg_dfr;
                    tx_cnt_d = '0;
                    state_d  = ST_CFG_DFR;
                end
            end
            ST_CFG_DFR: state_d = cfg_stop ? ST_IDLE : ST_CFG_CR;
            ST_CFG_CR:  state_d = cfg_stop ? ST_IDLE : ST_POLL;
            ST_POLL: begin
                if (cfg_stop) begin
                    state_d = ST_IDLE;
                end else if (!rd[TX_FULL_BIT]) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // tx_full lags a FIFO write by one cycle, so every write is
                // followed by a fresh poll.
                if (s_valid) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    state_d  = ST_POLL;
                end
                if (cfg_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and stream outputs decoded from state. Held idle during the reset
    // cycle so that a reset landing in SEND cannot issue a write.
    always_comb begin
        addr    = 5'h00;
        re      = 1'b0;
        we      = 1'b0;
        wd      = 32'h0;
        s_ready = 1'b0;
        if (!rstn) begin
            case (state_q)
                ST_CFG_DFR: begin
                    we   = 1'b1;
                    addr = UART_DFR;
                    wd   = {16'h0, dfr_q};
                end
                ST_CFG_CR: begin
                    we   = 1'b1;
                    addr = UART_CR;
                    wd   = {24'h0, CR_INIT};
                end
                ST_POLL: begin
                    re   = 1'b1;
                    addr = UART_CR;
                end
                ST_SEND: begin
                    // Only this block fills the TX FIFO, so waiting here for
                    // s_valid cannot let the FIFO become full behind our back.
                    s_ready = 1'b1;
                    if (s_valid) begin
                        we   = 1'b1;
                        addr = UART_TX_RX;
                        wd   = {24'h0, s_data};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign tx_cnt = tx_cnt_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= ST_IDLE;
            dfr_q    <= '0;
            tx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dfr_q    <= dfr_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rstn;
  logic                cfg_start;
  logic                cfg_stop;
  logic [15:0]         cfg_dfr;
  logic                busy;
  logic                s_valid;
  logic [7:0]          s_data;
  logic                s_ready;
  logic [4:0]          addr;
  logic                re;
  logic                we;
  logic [31:0]         wd;
  logic [31:0]         rd;
  logic [TB_CNT_W-1:0] tx_cnt;
  logic                tx_full;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  uart_tx_feeder #(
    .CR_INIT(8'h01),
    .TX_FULL_BIT(6),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cfg_start(cfg_start),
    .cfg_stop(cfg_stop),
    .cfg_dfr(cfg_dfr),
    .busy(busy),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .addr(addr),
    .re(re),
    .we(we),
    .wd(wd),
    .rd(rd),
    .tx_cnt(tx_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart status word model: only tx_full is meaningful
  assign rd = {25'h0, tx_full, 6'h0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_write);
    src_q.push_back(b);
    if (expect_write) exp_q.push_back(b);
  endtask

  // stream source driver: offers the head of src_q
  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(negedge clk);
      s_valid = (src_q.size() != 0);
      s_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end
  end

  // monitor / scoreboard, sampled mid-low-phase
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (s_valid && s_ready && src_q.size() != 0) void'(src_q.pop_front());
      chk("no_rx_read", {31'h0, re && addr == UART_TX_RX}, 32'h0);
      chk("we_re_excl", {31'h0, re && we}, 32'h0);
      if (we && addr == UART_TX_RX) begin
        if (exp_q.size() == 0) chk("tx_unexpected", wd, 32'hDEAD_BEEF);
        else chk("tx_data", wd, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_we"}, {31'h0, we}, 32'h0);
    chk({tag, "_re"}, {31'h0, re}, 32'h0);
    chk({tag, "_addr"}, {27'h0, addr}, 32'h0);
    chk({tag, "_wd"}, wd, 32'h0);
    chk({tag, "_rdy"}, {31'h0, s_ready}, 32'h0);
  endtask

  initial begin
    bit done;
    rstn = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_dfr = 16'h0; tx_full = 1'b0;
    repeat (3) tick();
    #4;
    chk_idle_bus("rst");
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cnt", {28'h0, tx_cnt}, 32'h0);
    tick(); rstn = 1'b0;

    // configuration sequence
    tick(); cfg_start = 1'b1; cfg_dfr = 16'h0036; #4;
    chk("idle_busy", {31'h0, busy}, 32'h0);
    tick(); cfg_start = 1'b0; #4;
    chk("dfr_we", {31'h0, we}, 32'h1);
    chk("dfr_addr", {27'h0, addr}, 32'h08);
    chk("dfr_wd", wd, 32'h36);
    tick(); #4;
    chk("cr_we", {31'h0, we}, 32'h1);
    chk("cr_addr", {27'h0, addr}, 32'h00);
    chk("cr_wd", wd, 32'h01);
    tick(); #4;
    chk("poll_re", {31'h1 & 31'h0, re}, 32'h1);
    chk("poll_addr", {27'h0, addr}, 32'h00);
    chk("poll_busy", {31'h0, busy}, 32'h1);

    // back-to-back burst: SEND,POLL,SEND,POLL,SEND
    push_byte(8'hA5, 1); push_byte(8'h5A, 1); push_byte(8'hFF, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); #4;
      chk("burst_we", {31'h0, we}, {31'h0, i % 2 == 0});
      chk("burst_rdy", {31'h0, s_ready}, {31'h0, i % 2 == 0});
      chk("burst_re", {31'h0, re}, {31'h0, i % 2 == 1});
    end

    // tx_full held for 10 cycles while a byte is pending
    tick(); tx_full = 1'b1; #4;
    chk("burst_cnt", {28'h0, tx_cnt}, 32'h3);
    chk("full_re0", {31'h0, re}, 32'h1);
    push_byte(8'h3C, 1);
    for (int i = 0; i < 10; i++) begin
      tick(); #4;
      chk("full_re", {31'h0, re}, 32'h1);
      chk("full_we", {31'h0, we}, 32'h0);
      chk("full_rdy", {31'h0, s_ready}, 32'h0);
    end
    tick(); tx_full = 1'b0; #4;
    chk("unfull_re", {31'h0, re}, 32'h1);
    tick(); #4;
    chk("unfull_we", {31'h0, we}, 32'h1);
    chk("unfull_wd", wd, 32'h3C);

    // stop together with an accepted byte
    push_byte(8'h42, 1);
    tick(); #4;
    chk("stop_poll_re", {31'h0, re}, 32'h1);
    tick(); cfg_stop = 1'b1; #4;
    chk("stop_we", {31'h0, we}, 32'h1);
    chk("stop_wd", wd, 32'h42);
    tick(); cfg_stop = 1'b0; #4;
    chk("stop_busy", {31'h0, busy}, 32'h0);
    chk("stop_cnt", {28'h0, tx_cnt}, 32'h5);
    chk_idle_bus("stop");

    // restart; start while busy is ignored
    tick(); cfg_start = 1'b1; cfg_dfr = 16'h0010; #4;
    tick(); cfg_start = 1'b0; #4;
    chk("re_cnt", {28'h0, tx_cnt}, 32'h0);
    chk("re_dfr_addr", {27'h0, addr}, 32'h08);
    chk("re_dfr_wd", wd, 32'h10);
    tick(); cfg_start = 1'b1; cfg_dfr = 16'h0077; #4;
    chk("busy_start_addr", {27'h0, addr}, 32'h00);
    chk("busy_start_wd", wd, 32'h01);
    tick(); cfg_start = 1'b0; #4;
    chk("busy_start_re", {31'h0, re}, 32'h1);

    // reset while in SEND with a valid byte: no write
    push_byte(8'h99, 0);
    tick(); rstn = 1'b1; #4;
    chk("rst_send_we", {31'h0, we}, 32'h0);
    chk("rst_send_rdy", {31'h0, s_ready}, 32'h0);
    tick(); rstn = 1'b0; src_q.delete(); #4;
    chk_idle_bus("rst2");
    chk("rst2_busy", {31'h0, busy}, 32'h0);
    chk("rst2_cnt", {28'h0, tx_cnt}, 32'h0);

    // start and stop together in IDLE: start wins; then stop in POLL
    tick(); cfg_start = 1'b1; cfg_stop = 1'b1; cfg_dfr = 16'h0005; #4;
    tick(); cfg_start = 1'b0; cfg_stop = 1'b0; #4;
    chk("both_busy", {31'h0, busy}, 32'h1);
    chk("both_wd", wd, 32'h05);
    tick(); #4;
    tick(); cfg_stop = 1'b1; #4;
    chk("pstop_re", {31'h0, re}, 32'h1);
    tick(); cfg_stop = 1'b0; #4;
    chk("pstop_busy", {31'h0, busy}, 32'h0);

    // stop during CFG_DFR: the write completes, then idle
    tick(); cfg_start = 1'b1; cfg_dfr = 16'h1234; #4;
    tick(); cfg_start = 1'b0; cfg_stop = 1'b1; #4;
    chk("dstop_we", {31'h0, we}, 32'h1);
    chk("dstop_wd", wd, 32'h1234);
    tick(); cfg_stop = 1'b0; #4;
    chk("dstop_busy", {31'h0, busy}, 32'h0);
    chk("dstop_we2", {31'h0, we}, 32'h0);

    // 17 random bytes with random backpressure: counter wraps to 1
    tick(); cfg_start = 1'b1; cfg_dfr = 16'h0001; #4;
    tick(); cfg_start = 1'b0; #4;
    for (int i = 0; i < 17; i++) push_byte(8'($urandom_range(0, 255)), 1);
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick(); tx_full = ($urandom_range(0, 3) == 0); #4;
      if (src_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", {31'h0, done}, 32'h1);
    tick(); tx_full = 1'b0; #4;
    chk("wrap_cnt", {28'h0, tx_cnt}, 32'h1);
    chk("exp_q_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
